muldiv_unit: RTL

//   Multi-cycle execute unit for RV32M MUL/DIV/REM ops, issued from the reservation-station dispatch path.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide execute unit.
// Fixed-latency multiply, radix-2 restoring divide, valid/ready result port.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_opd1,
  input  logic [XLEN-1:0]  in_opd2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_value,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LAST =
    CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  out_value_q, out_value_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic idle;
  assign idle      = (state_q == S_IDLE);
  assign in_ready  = idle & ~flush;
  assign out_valid = (state_q == S_DONE);
  assign out_value = out_value_q;
  assign out_tag   = out_tag_q;

  // Multiplier reads the live inputs in IDLE so a 1-stage MUL can finish
  logic [2:0]        m_op;
  logic [XLEN-1:0]   m_a, m_b;
  logic              m_sa, m_sb;
  logic [2*XLEN-1:0] m_ax, m_bx, prod;
  logic [XLEN-1:0]   mul_res;
  assign m_op    = idle ? in_op : op_q;
  assign m_a     = idle ? in_opd1 : a_q;
  assign m_b     = idle ? in_opd2 : b_q;
  assign m_sa    = (m_op == 3'd1) | (m_op == 3'd2);
  assign m_sb    = (m_op == 3'd1);
  assign m_ax    = {{XLEN{m_sa & m_a[XLEN-1]}}, m_a};
  assign m_bx    = {{XLEN{m_sb & m_b[XLEN-1]}}, m_b};
  assign prod    = m_ax * m_bx;
  assign mul_res = (m_op[1:0] == 2'd0) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];

  // One restoring-division step on magnitudes
  logic [XLEN:0]   d_part, d_diff;
  logic            d_bit;
  logic [XLEN-1:0] d_rem, d_quo;
  assign d_part = {rem_q, quo_q[XLEN-1]};
  assign d_diff = d_part - {1'b0, dvs_q};
  assign d_bit  = ~d_diff[XLEN];
  assign d_rem  = d_bit ? d_diff[XLEN-1:0] : d_part[XLEN-1:0];
  assign d_quo  = {quo_q[XLEN-2:0], d_bit};

  // Sign fix-up applied on the last iteration
  logic            sgn, neg_q, neg_r;
  logic [XLEN-1:0] div_res;
  assign sgn     = ~op_q[0];
  assign neg_q   = sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign neg_r   = sgn & a_q[XLEN-1];
  assign div_res = op_q[1] ? (neg_r ? -d_rem : d_rem)
                           : (neg_q ? -d_quo : d_quo);

  // Accept-time decode: magnitudes and the no-iteration cases
  logic            i_sgn, i_dz, i_ovf;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  assign i_sgn = ~in_op[0];
  assign i_dz  = (in_opd2 == '0);
  assign i_ovf = i_sgn & (in_opd1 == MIN_VAL) & (in_opd2 == '1);
  assign a_abs = (i_sgn & in_opd1[XLEN-1]) ? -in_opd1 : in_opd1;
  assign b_abs = (i_sgn & in_opd2[XLEN-1]) ? -in_opd2 : in_opd2;
  assign fast_res = i_dz ? (in_op[1] ? in_opd1 : '1)
                         : (in_op[1] ? '0 : MIN_VAL);

  // Next-state and datapath update; flush overrides every transition
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    out_value_d = out_value_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d  = in_op;
            a_d   = in_opd1;
            b_d   = in_opd2;
            tag_d = in_tag;
            cnt_d = '0;
            if (in_op[2]) begin
              if (i_dz | i_ovf) begin
                out_value_d = fast_res;
                out_tag_d   = in_tag;
                state_d     = S_DONE;
              end else begin
                rem_d   = '0;
                quo_d   = a_abs;
                dvs_d   = b_abs;
                state_d = S_DIV;
              end
            end else if (MUL_STAGES == 1) begin
              out_value_d = mul_res;
              out_tag_d   = in_tag;
              state_d     = S_DONE;
            end else begin
              state_d = S_MUL;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) begin
            out_value_d = mul_res;
            out_tag_d   = tag_q;
            state_d     = S_DONE;
          end
        end
        S_DIV: begin
          cnt_d = cnt_q + 1'b1;
          rem_d = d_rem;
          quo_d = d_quo;
          if (cnt_q == DIV_LAST) begin
            out_value_d = div_res;
            out_tag_d   = tag_q;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      out_value_q <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      out_value_q <= out_value_d;
      out_tag_q   <= out_tag_d;
    end
  end
endmodule
